// File: rtl/frame_pkt_pkg.sv
// Shared types and packet geometry for the frame line packetizer.
package frame_pkt_pkg;

  typedef enum logic [1:0] {IDLE, HDR, PIX, GAP} state_t;

  localparam int HDR_BYTES       = 3;
  localparam int BYTES_PER_PIXEL = 3;

  // Bytes in one line packet: header followed by R,G,B for every pixel.
  function automatic int pkt_len(input int h_pixels);
    return HDR_BYTES + BYTES_PER_PIXEL * h_pixels;
  endfunction

endpackage

// File: rtl/frame_line_packetizer.sv
// Streams a captured frame out of pixel BRAM as one byte-wide packet per line:
// {frame_id, line_hi, line_lo} then R,G,B per pixel, with an idle gap between packets.
module frame_line_packetizer
  import frame_pkt_pkg::*;
#(
  parameter int H_PIXELS   = 320,
  parameter int V_LINES    = 180,
  parameter int ADDR_W     = 16,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk125MHz,
  input  logic              rstb,
  input  logic              start_frame,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [23:0]       bram_dout,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic              busy,
  output logic [7:0]        frame_id
);

  localparam int PKT_LEN = pkt_len(H_PIXELS);
  localparam int POS_W   = $clog2(PKT_LEN);
  localparam int GAP_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [POS_W-1:0]  POS_HDR0    = '0;
  localparam logic [POS_W-1:0]  POS_HDR1    = POS_W'(1);
  localparam logic [POS_W-1:0]  POS_LAST    = POS_W'(PKT_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(IFG_CYCLES - 1);
  localparam logic [15:0]       LINE_LAST   = 16'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_PIXELS);

  state_t            state;
  logic [POS_W-1:0]  pos;      // index of the byte currently on tx_data
  logic [1:0]        rgb_sel;  // 0=R, 1=G, 2=B of the pixel on tx_data
  logic [15:0]       line;
  logic [ADDR_W-1:0] base;     // address of pixel 0 of the current line
  logic [23:0]       pix;
  logic [GAP_W-1:0]  gap_cnt;
  logic              pending;

  logic accept;
  logic last_line;

  assign accept    = tx_valid && tx_ready;
  assign last_line = (line == LINE_LAST);

  // NOTE: everything below is clocked state, so only non-blocking assignments are used.
  always_ff @(posedge clk125MHz) begin
    if (rstb) begin
      // NOTE: pix is left out of reset; it is always reloaded from BRAM before use.
      state     <= IDLE;
      pos       <= '0;
      rgb_sel   <= '0;
      line      <= '0;
      base      <= '0;
      gap_cnt   <= '0;
      pending   <= 1'b0;
      bram_addr <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_last   <= 1'b0;
      busy      <= 1'b0;
      frame_id  <= '0;
    end else begin
      if (start_frame && busy) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start_frame) begin
            state     <= HDR;
            busy      <= 1'b1;
            line      <= '0;
            base      <= '0;
            bram_addr <= '0;
            pos       <= '0;
            tx_valid  <= 1'b1;
            tx_data   <= frame_id;
            tx_last   <= 1'b0;
          end
        end

        HDR: begin
          if (accept) begin
            pos <= pos + 1'b1;
            if (pos == POS_HDR0) begin
              tx_data <= line[15:8];
            end else if (pos == POS_HDR1) begin
              tx_data <= line[7:0];
            end else begin
              // Pixel 0 has been addressed since HDR entry, so bram_dout is settled.
              tx_data   <= bram_dout[23:16];
              pix       <= bram_dout;
              bram_addr <= bram_addr + 1'b1;
              rgb_sel   <= 2'd0;
              state     <= PIX;
            end
          end
        end

        PIX: begin
          if (accept) begin
            pos <= pos + 1'b1;
            case (rgb_sel)
              2'd0: begin
                tx_data <= pix[15:8];
                rgb_sel <= 2'd1;
              end
              2'd1: begin
                tx_data <= pix[7:0];
                tx_last <= ((pos + 1'b1) == POS_LAST);
                rgb_sel <= 2'd2;
              end
              default: begin
                if (tx_last) begin
                  tx_valid <= 1'b0;
                  tx_last  <= 1'b0;
                  gap_cnt  <= '0;
                  state    <= GAP;
                  if (last_line) frame_id <= frame_id + 8'd1;
                end else begin
                  // Next pixel's word arrives straight from BRAM; the R byte can't wait a cycle.
                  tx_data   <= bram_dout[23:16];
                  pix       <= bram_dout;
                  bram_addr <= bram_addr + 1'b1;
                  rgb_sel   <= 2'd0;
                end
              end
            endcase
          end
        end

        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            if (!last_line || pending) begin
              state    <= HDR;
              pos      <= '0;
              tx_valid <= 1'b1;
              tx_data  <= frame_id;
              if (last_line) begin
                pending   <= 1'b0;
                line      <= '0;
                base      <= '0;
                bram_addr <= '0;
              end else begin
                line      <= line + 16'd1;
                base      <= base + LINE_STRIDE;
                bram_addr <= base + LINE_STRIDE;
              end
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_line_packetizer.sv
// Directed bench for frame_line_packetizer: a 4x2 frame instance for packet content and
// flow control, and a 4x1 instance for frame_id wrap-around.
module tb_frame_line_packetizer;
  import frame_pkt_pkg::*;

  localparam int TB_H   = 4;
  localparam int TB_V   = 2;
  localparam int TB_IFG = 3;
  localparam int TB_PKT = 3 + 3 * TB_H;

  logic        clk;
  logic        rstb;
  logic        start_frame, tx_ready;
  logic [15:0] bram_addr;
  logic [23:0] bram_dout;
  logic        tx_valid, tx_last, busy;
  logic [7:0]  tx_data, frame_id;

  logic        start_w, ready_w;
  logic [15:0] bram_addr_w;
  logic [23:0] bram_dout_w;
  logic        tx_valid_w, tx_last_w, busy_w;
  logic [7:0]  tx_data_w, frame_id_w;

  int vectors;
  int miscompares;

  frame_line_packetizer #(.H_PIXELS(TB_H), .V_LINES(TB_V), .ADDR_W(16), .IFG_CYCLES(TB_IFG)) dut (
    .clk125MHz(clk), .rstb(rstb), .start_frame(start_frame), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .frame_id(frame_id)
  );

  frame_line_packetizer #(.H_PIXELS(TB_H), .V_LINES(1), .ADDR_W(16), .IFG_CYCLES(TB_IFG)) dut_w (
    .clk125MHz(clk), .rstb(rstb), .start_frame(start_w), .bram_addr(bram_addr_w),
    .bram_dout(bram_dout_w), .tx_valid(tx_valid_w), .tx_data(tx_data_w), .tx_last(tx_last_w),
    .tx_ready(ready_w), .busy(busy_w), .frame_id(frame_id_w)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  // Registered-read BRAM model: data for an address appears one cycle later.
  always @(posedge clk) begin
    bram_dout   <= {bram_addr[7:0], ~bram_addr[7:0], 8'hA5};
    bram_dout_w <= {bram_addr_w[7:0], ~bram_addr_w[7:0], 8'hA5};
  end

  function automatic logic [7:0] exp_byte(input logic [7:0] fid, input int ln, input int idx);
    int p;
    logic [7:0] a8;
    if (idx == 0) return fid;
    if (idx == 1) return 8'(ln >> 8);
    if (idx == 2) return 8'(ln);
    p  = (idx - 3) / 3;
    a8 = 8'(ln * TB_H + p);
    case ((idx - 3) % 3)
      0:       return a8;
      1:       return ~a8;
      default: return 8'hA5;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Receives one line packet, comparing every presented byte and tx_last, and checking
  // that stalled cycles hold their byte. With rnd=0 the packet must have no bubbles.
  task automatic rx_packet(input logic [7:0] fid, input int ln, input bit rnd, input bit pulse_last);
    int idx = 0;
    int cyc = 0;
    bit started = 0;
    bit stalled = 0;
    logic [7:0] held_d = '0;
    logic held_l = 1'b0;
    while (idx < TB_PKT && cyc < 400) begin
      start_frame = 1'b0;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== held_d || tx_last !== held_l) begin
          miscompares++;
          $display("FAIL stall_hold f%0d l%0d byte%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   fid, ln, idx, tx_valid, tx_data, tx_last, held_d, held_l);
        end
      end
      if (tx_valid === 1'b1) begin
        started = 1;
        vectors++;
        if (tx_data !== exp_byte(fid, ln, idx)) begin
          miscompares++;
          $display("FAIL pkt_data f%0d l%0d byte%0d: got %h want %h", fid, ln, idx, tx_data,
                   exp_byte(fid, ln, idx));
        end
        vectors++;
        if (tx_last !== (idx == TB_PKT - 1)) begin
          miscompares++;
          $display("FAIL pkt_last f%0d l%0d byte%0d: got %b want %b", fid, ln, idx, tx_last,
                   (idx == TB_PKT - 1));
        end
        if (pulse_last && idx == TB_PKT - 1 && tx_ready) start_frame = 1'b1;
        stalled = !tx_ready;
        held_d  = tx_data;
        held_l  = tx_last;
        if (tx_ready) idx++;
      end else begin
        if (started && !rnd) begin
          vectors++;
          miscompares++;
          $display("FAIL pkt_bubble f%0d l%0d byte%0d: got tx_valid=0 want 1", fid, ln, idx);
        end
        stalled = 0;
      end
      step();
      cyc++;
    end
    start_frame = 1'b0;
    if (idx < TB_PKT) begin
      vectors++;
      miscompares++;
      $display("FAIL pkt_timeout f%0d l%0d: got %0d bytes want %0d", fid, ln, idx, TB_PKT);
    end
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    start_frame = 1'b1;
    tx_ready = 1'b1;
    start_w = 1'b0;
    ready_w = 1'b1;
    repeat (2) step();
    rstb = 1'b0;
    start_frame = 1'b0;
    vectors++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_last !== 1'b0 || bram_addr !== 16'h0000 ||
        busy !== 1'b0 || frame_id !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b a=%h busy=%b id=%h, want all zero",
               tx_valid, tx_data, tx_last, bram_addr, busy, frame_id);
    end
    vectors++;
    if (dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE);
    end
    step();
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_ignored: got v=%b busy=%b want 0 0", tx_valid, busy);
    end
  endtask

  task automatic test_single_frame();
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    vectors++;
    if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL start_latency: got v=%b busy=%b d=%h want 1 1 00", tx_valid, busy, tx_data);
    end
    rx_packet(8'h00, 0, 1'b0, 1'b0);
    for (int g = 0; g < TB_IFG; g++) begin
      vectors++;
      if (tx_valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL line_gap cycle%0d: got v=%b busy=%b want 0 1", g, tx_valid, busy);
      end
      step();
    end
    vectors++;
    if (tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL line_gap_end: got v=%b want 1", tx_valid);
    end
    rx_packet(8'h00, 1, 1'b0, 1'b0);
    for (int g = 0; g < TB_IFG; g++) begin
      vectors++;
      if (tx_valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL final_gap cycle%0d: got v=%b busy=%b want 0 1", g, tx_valid, busy);
      end
      step();
    end
    vectors++;
    if (busy !== 1'b0 || dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL busy_fall: got busy=%b state=%0d want 0 %0d", busy, dut.state, IDLE);
    end
    vectors++;
    if (frame_id !== 8'h01) begin
      miscompares++;
      $display("FAIL frame_id_inc: got %h want 01", frame_id);
    end
  endtask

  task automatic test_random_ready();
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    rx_packet(8'h01, 0, 1'b1, 1'b0);
    rx_packet(8'h01, 1, 1'b1, 1'b0);
    tx_ready = 1'b1;
    wait_idle();
    vectors++;
    if (frame_id !== 8'h02) begin
      miscompares++;
      $display("FAIL frame_id_rand: got %h want 02", frame_id);
    end
  endtask

  task automatic test_pending();
    bit extra = 0;
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    tx_ready = 1'b0;
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    step();
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h02) begin
      miscompares++;
      $display("FAIL stall_header: got v=%b d=%h want 1 02", tx_valid, tx_data);
    end
    rx_packet(8'h02, 0, 1'b0, 1'b0);
    rx_packet(8'h02, 1, 1'b0, 1'b0);
    rx_packet(8'h03, 0, 1'b0, 1'b0);
    // A request landing on the final accepted byte must be kept.
    rx_packet(8'h03, 1, 1'b0, 1'b1);
    rx_packet(8'h04, 0, 1'b0, 1'b0);
    rx_packet(8'h04, 1, 1'b0, 1'b0);
    wait_idle();
    for (int c = 0; c < 30; c++) begin
      if (tx_valid !== 1'b0) extra = 1;
      step();
    end
    vectors++;
    if (extra) begin
      miscompares++;
      $display("FAIL dropped_pulse: got extra frame want none");
    end
    vectors++;
    if (frame_id !== 8'h05) begin
      miscompares++;
      $display("FAIL frame_id_pending: got %h want 05", frame_id);
    end
  endtask

  task automatic test_reset_mid_packet();
    tx_ready = 1'b1;
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    repeat (6) step();
    vectors++;
    if (dut.state !== PIX || tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pix: got state=%0d v=%b want %0d 1", dut.state, tx_valid, PIX);
    end
    rstb = 1'b1;
    step();
    rstb = 1'b0;
    vectors++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || busy !== 1'b0 || frame_id !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b l=%b busy=%b id=%h want 0 0 0 00",
               tx_valid, tx_last, busy, frame_id);
    end
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    rx_packet(8'h00, 0, 1'b0, 1'b0);
    rx_packet(8'h00, 1, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_frame_id_wrap();
    int cyc;
    ready_w = 1'b1;
    for (int f = 0; f < 257; f++) begin
      start_w = 1'b1;
      step();
      start_w = 1'b0;
      vectors++;
      if (tx_valid_w !== 1'b1 || tx_data_w !== 8'(f)) begin
        miscompares++;
        $display("FAIL wrap_header frame%0d: got v=%b d=%h want 1 %h", f, tx_valid_w, tx_data_w,
                 8'(f));
      end
      cyc = 0;
      while (busy_w === 1'b1 && cyc < 100) begin
        step();
        cyc++;
      end
      if (busy_w !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL wrap_timeout frame%0d: got busy=%b want 0", f, busy_w);
      end
    end
    vectors++;
    if (frame_id_w !== 8'h01) begin
      miscompares++;
      $display("FAIL wrap_final_id: got %h want 01", frame_id_w);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstb = 1'b1;
    start_frame = 1'b0;
    tx_ready = 1'b1;
    start_w = 1'b0;
    ready_w = 1'b1;
    test_reset();
    test_single_frame();
    test_random_ready();
    test_pending();
    test_reset_mid_packet();
    test_frame_id_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
